// File: rtl/butterfly_writeback.sv
`default_nettype none
// ============================================================================
// Module   : butterfly_writeback
// Purpose  : Captures one butterfly result and issues four ordered SRAM
//            write beats (a_real, a_imag, b_real, b_imag). The optional
//            address-collision flag is enabled by WB_COLLISION_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module butterfly_writeback #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              result_valid,
  output logic              result_ready,
  input  logic [ADDR_W-1:0] a_real_addr,
  input  logic [ADDR_W-1:0] a_imag_addr,
  input  logic [ADDR_W-1:0] b_real_addr,
  input  logic [ADDR_W-1:0] b_imag_addr,
  input  logic [DATA_W-1:0] a_real_data,
  input  logic [DATA_W-1:0] a_imag_data,
  input  logic [DATA_W-1:0] b_real_data,
  input  logic [DATA_W-1:0] b_imag_data,
  input  logic              mem_ready,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic [2:0]        samples_stored_count,
  output logic              writeback_done
`ifdef WB_COLLISION_CHECK_EN
  ,
  output logic              addr_collision
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_beat;
  logic [1:0]        w_beat_nxt;
  logic              w_capture;

  logic [ADDR_W-1:0] r_addr0, r_addr1, r_addr2, r_addr3;
  logic [DATA_W-1:0] r_data0, r_data1, r_data2, r_data3;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_addr0 <= '0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_addr3 <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_data3 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (w_capture) begin
        r_addr0 <= a_real_addr;
        r_addr1 <= a_imag_addr;
        r_addr2 <= b_real_addr;
        r_addr3 <= b_imag_addr;
        r_data0 <= a_real_data;
        r_data1 <= a_imag_data;
        r_data2 <= b_real_data;
        r_data3 <= b_imag_data;
      end
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_beat_nxt           = r_beat;
    w_capture            = 1'b0;
    result_ready         = 1'b0;
    write_enable         = 1'b0;
    writeback_done       = 1'b0;
    samples_stored_count = 3'd0;
    case (r_state)
      S_IDLE: begin
        result_ready = 1'b1;
        if (result_valid) begin
          w_capture   = 1'b1;
          w_beat_nxt  = 2'd0;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        write_enable         = 1'b1;
        samples_stored_count = {1'b0, r_beat};
        if (mem_ready) begin
          w_beat_nxt = r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        writeback_done       = 1'b1;
        samples_stored_count = 3'd4;
        w_state_nxt          = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs come only from holding registers so no input reaches write_* combinationally.
  always_comb begin
    write_address = '0;
    write_data    = '0;
    if (r_state == S_WRITE) begin
      case (r_beat)
        2'd0:    begin write_address = r_addr0; write_data = r_data0; end
        2'd1:    begin write_address = r_addr1; write_data = r_data1; end
        2'd2:    begin write_address = r_addr2; write_data = r_data2; end
        default: begin write_address = r_addr3; write_data = r_data3; end
      endcase
    end
  end

`ifdef WB_COLLISION_CHECK_EN
  logic r_addr_collision;
  logic w_collision;

  assign w_collision = (a_real_addr == a_imag_addr) || (a_real_addr == b_real_addr) ||
                       (a_real_addr == b_imag_addr) || (a_imag_addr == b_real_addr) ||
                       (a_imag_addr == b_imag_addr) || (b_real_addr == b_imag_addr);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_addr_collision <= 1'b0;
    end else if (w_capture) begin
      r_addr_collision <= w_collision;
    end
  end

  assign addr_collision = r_addr_collision;
`endif

endmodule
`default_nettype wire

// File: tb/tb_butterfly_writeback.sv
`default_nettype none
// Testbench for butterfly_writeback: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_butterfly_writeback;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              nrst;
  logic              result_valid;
  logic              result_ready;
  logic [ADDR_W-1:0] a_real_addr, a_imag_addr, b_real_addr, b_imag_addr;
  logic [DATA_W-1:0] a_real_data, a_imag_data, b_real_data, b_imag_data;
  logic              mem_ready;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic [2:0]        samples_stored_count;
  logic              writeback_done;
`ifdef WB_COLLISION_CHECK_EN
  logic              addr_collision;
`endif

  butterfly_writeback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .a_real_addr         (a_real_addr),
    .a_imag_addr         (a_imag_addr),
    .b_real_addr         (b_real_addr),
    .b_imag_addr         (b_imag_addr),
    .a_real_data         (a_real_data),
    .a_imag_data         (a_imag_data),
    .b_real_data         (b_real_data),
    .b_imag_data         (b_imag_data),
    .mem_ready           (mem_ready),
    .write_enable        (write_enable),
    .write_address       (write_address),
    .write_data          (write_data),
    .samples_stored_count(samples_stored_count),
    .writeback_done      (writeback_done)
`ifdef WB_COLLISION_CHECK_EN
    ,
    .addr_collision      (addr_collision)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a result becomes four pending beats, consumed on mem_ready.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;
  beat_t q_beats[$];
  bit    mdl_done = 1'b0;
  bit    mdl_coll = 1'b0;
  bit    mdl_on   = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!nrst) begin
      q_beats.delete();
      mdl_done = 1'b0;
      mdl_coll = 1'b0;
    end else if (q_beats.size() > 0) begin
      if (mem_ready) begin
        void'(q_beats.pop_front());
        if (q_beats.size() == 0) mdl_done = 1'b1;
      end
    end else if (mdl_done) begin
      mdl_done = 1'b0;
    end else if (result_valid) begin
      logic [ADDR_W-1:0] a[4];
      a[0] = a_real_addr; a[1] = a_imag_addr; a[2] = b_real_addr; a[3] = b_imag_addr;
      q_beats.push_back('{a_real_addr, a_real_data});
      q_beats.push_back('{a_imag_addr, a_imag_data});
      q_beats.push_back('{b_real_addr, b_real_data});
      q_beats.push_back('{b_imag_addr, b_imag_data});
      mdl_coll = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (a[i] == a[j]) mdl_coll = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mdl_on) begin
      bit busy;
      busy = (q_beats.size() > 0);
      chk("m_ready", result_ready, (!busy && !mdl_done));
      chk("m_we", write_enable, busy);
      chk("m_addr", write_address, busy ? q_beats[0].addr : '0);
      chk("m_data", write_data, busy ? q_beats[0].data : '0);
      chk("m_count", samples_stored_count, busy ? 4 - q_beats.size() : (mdl_done ? 4 : 0));
      chk("m_done", writeback_done, mdl_done);
`ifdef WB_COLLISION_CHECK_EN
      chk("m_coll", addr_collision, mdl_coll);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic [ADDR_W-1:0] a0, a1, a2, a3,
                         input logic [DATA_W-1:0] d0, d1, d2, d3);
    a_real_addr = a0; a_imag_addr = a1; b_real_addr = a2; b_imag_addr = a3;
    a_real_data = d0; a_imag_data = d1; b_real_data = d2; b_imag_data = d3;
  endtask

  task automatic basic_run(input string tag);
    set_res(10'h010, 10'h011, 10'h210, 10'h211, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    chk({tag, "_b0_we"}, write_enable, 1);
    chk({tag, "_b0_addr"}, write_address, 10'h010);
    chk({tag, "_b0_data"}, write_data, 16'h1111);
    chk({tag, "_b0_cnt"}, samples_stored_count, 0);
    step();
    chk({tag, "_b1_addr"}, write_address, 10'h011);
    chk({tag, "_b1_cnt"}, samples_stored_count, 1);
    step();
    chk({tag, "_b2_data"}, write_data, 16'h3333);
    chk({tag, "_b2_cnt"}, samples_stored_count, 2);
    step();
    chk({tag, "_b3_addr"}, write_address, 10'h211);
    chk({tag, "_b3_data"}, write_data, 16'h4444);
    step();
    chk({tag, "_done"}, writeback_done, 1);
    chk({tag, "_done_cnt"}, samples_stored_count, 4);
    chk({tag, "_done_we"}, write_enable, 0);
    chk({tag, "_done_rdy"}, result_ready, 0);
    step();
    chk({tag, "_idle_rdy"}, result_ready, 1);
    chk({tag, "_idle_done"}, writeback_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    result_valid = 1'b0;
    mem_ready = 1'b1;
    set_res('0, '0, '0, '0, '0, '0, '0, '0);
    step();
    step();
    mdl_on = 1'b1;
    chk("rst_ready", result_ready, 1);
    chk("rst_we", write_enable, 0);
    chk("rst_cnt", samples_stored_count, 0);
    chk("rst_done", writeback_done, 0);
    nrst = 1'b1;
    step();

    basic_run("basic");

    // Two stall cycles on beat 2: it must be shown for three cycles.
    set_res(10'h010, 10'h011, 10'h210, 10'h211, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    step();
    step();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ws_addr", write_address, 10'h210);
      chk("ws_data", write_data, 16'h3333);
      if (k == 2) mem_ready = 1'b1;
      step();
    end
    chk("ws_b3_addr", write_address, 10'h211);
    step();
    chk("ws_done_n7", writeback_done, 1);
    step();

    // New result offered while busy must be ignored.
    set_res(10'h010, 10'h011, 10'h210, 10'h211, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    result_valid = 1'b1;
    step();
    set_res(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    for (int k = 0; k < 4; k++) begin
      chk("busy_ready", result_ready, 0);
      step();
    end
    result_valid = 1'b0;
    chk("busy_done", writeback_done, 1);
    step();

    // Reset on the cycle after beat 1 is accepted.
    set_res(10'h010, 10'h011, 10'h210, 10'h211, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    step();
    step();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    chk("mrst_we", write_enable, 0);
    chk("mrst_ready", result_ready, 1);
    chk("mrst_addr", write_address, 0);
    chk("mrst_cnt", samples_stored_count, 0);
    for (int k = 0; k < 5; k++) begin
      chk("mrst_nodone", writeback_done, 0);
      step();
    end
    basic_run("fresh");

    // Back-to-back with result_valid held high.
    set_res(10'h001, 10'h002, 10'h003, 10'h004, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
    result_valid = 1'b1;
    step();
    set_res(10'h101, 10'h102, 10'h103, 10'h104, 16'hB001, 16'hB002, 16'hB003, 16'hB004);
    for (int k = 0; k < 5; k++) step();
    chk("b2b_idle_ready", result_ready, 1);
    step();
    result_valid = 1'b0;
    chk("b2b_2nd_addr", write_address, 10'h101);
    chk("b2b_2nd_data", write_data, 16'hB001);
    for (int k = 0; k < 6; k++) step();

`ifdef WB_COLLISION_CHECK_EN
    set_res(10'h005, 10'h006, 10'h005, 10'h007, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    chk("coll_set", addr_collision, 1);
    for (int k = 0; k < 5; k++) step();
    set_res(10'h005, 10'h006, 10'h008, 10'h007, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    chk("coll_clr", addr_collision, 0);
    for (int k = 0; k < 5; k++) step();
`endif

    // Random traffic and stalls, checked by the model alone.
    for (int k = 0; k < 300; k++) begin
      mem_ready    = 1'($urandom_range(0, 1));
      result_valid = 1'($urandom_range(0, 1));
      set_res(10'($urandom), 10'($urandom_range(0, 3)), 10'($urandom), 10'($urandom_range(0, 3)),
              16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      step();
    end
    result_valid = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/butterfly_writeback.md
Name: butterfly_writeback

Overview:
Write-back sequencer for the FFT butterfly datapath. It captures one completed butterfly result: four data words plus their four SRAM addresses. It then issues four sequential SRAM write beats in the fixed order a_real, a_imag, b_real, b_imag, with a memory-ready handshake. This is the store-side counterpart to the load-side address sequencer. Beat index encoding matches the load side: 0 = a_real, 1 = a_imag, 2 = b_real, 3 = b_imag.

Parameters:
ADDR_W, 10, SRAM address width
DATA_W, 16, sample word width

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  synchronous active-low reset
result_valid  input  1  butterfly result and addresses present on inputs
result_ready  output  1  block can capture a result this cycle
a_real_addr  input  ADDR_W  destination address, beat 0
a_imag_addr  input  ADDR_W  destination address, beat 1
b_real_addr  input  ADDR_W  destination address, beat 2
b_imag_addr  input  ADDR_W  destination address, beat 3
a_real_data  input  DATA_W  data, beat 0
a_imag_data  input  DATA_W  data, beat 1
b_real_data  input  DATA_W  data, beat 2
b_imag_data  input  DATA_W  data, beat 3
mem_ready  input  1  SRAM accepts the current write this cycle
write_enable  output  1  write beat valid
write_address  output  ADDR_W  address of current beat
write_data  output  DATA_W  data of current beat
samples_stored_count  output  3  beats completed in current result (0..4)
writeback_done  output  1  one-cycle pulse after beat 3 is accepted

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on nrst, sampled only at the rising edge of clk.
- Reset values: state=IDLE, beat index=0, all holding registers 0, result_ready=1, write_enable=0, write_address=0, write_data=0, samples_stored_count=0, writeback_done=0.
- States: IDLE, WRITE, DONE.
- IDLE:
  - result_ready=1, write_enable=0.
  - Capture occurs when result_valid && result_ready. All eight inputs are latched into holding registers, the beat index is cleared to 0, and the next state is WRITE.
- WRITE:
  - result_ready=0 and write_enable=1.
  - write_address and write_data are driven from the holding registers selected by the beat index. Both are held stable while mem_ready=0.
  - A beat completes on a cycle with write_enable && mem_ready. The index then increments.
  - When beat 3 completes, the next state is DONE.
  - samples_stored_count equals the beat index.
- DONE:
  - writeback_done=1 for exactly this cycle.
  - samples_stored_count=4, write_enable=0, result_ready=0.
  - Next state is unconditionally IDLE.
- Latency:
  - With mem_ready held high, capture in cycle N gives beats in cycles N+1..N+4 and writeback_done in N+5.
  - The next capture is possible in N+6.
  - Each mem_ready=0 cycle during WRITE adds one cycle.
- result_valid while result_ready=0 is ignored. No capture occurs and the holding registers do not change.
- mem_ready outside WRITE is ignored.
- Write address and data are muxed directly from registered state. There are no combinational paths from inputs to write_* outputs.
- Reset mid-operation:
  - The next rising edge with nrst=0 aborts the transfer and forces reset values.
  - No further beats are issued for the aborted result and writeback_done is not pulsed.
- Duplicate addresses are written in order, so the last beat wins.
- Widths are passed through unchanged. No arithmetic is performed on data.

Optional Feature:
Macro: WB_COLLISION_CHECK_EN
- Defined:
  - Adds output addr_collision (1 bit, reset 0).
  - addr_collision is registered at capture. It is 1 if any two of the four captured addresses are equal, else 0.
  - It holds its value until the next capture or reset.
  - Write sequencing is unchanged.
- Not defined: the port and its compare logic are absent.

Test Plan:
- Basic write: mem_ready=1; capture addrs 0x010/0x011/0x210/0x211 with data 0x1111/0x2222/0x3333/0x4444. Expect:
  - write_enable high for 4 consecutive cycles, with (addr,data) pairs in that order;
  - samples_stored_count 0,1,2,3 across the beats, then 4;
  - writeback_done pulse in cycle N+5 and result_ready back to 1 in N+5+1.
- Wait states: same stimulus, mem_ready=0 for 2 cycles during beat 2. Expect:
  - write_address=0x210 and write_data=0x3333 stable for 3 cycles;
  - done in N+7.
- Busy ignore: assert result_valid with new values (addr 0x3FF) during WRITE. Expect the original four beats unchanged and result_ready=0 throughout.
- Reset mid-operation: drive nrst=0 on the cycle after beat 1 is accepted. Expect:
  - all outputs at reset values on the following cycle;
  - no beat 2/3 and no writeback_done;
  - a fresh capture afterwards works normally.
- Back-to-back: result_valid held high with two different results. Expect the second capture in the first IDLE cycle after DONE and 8 total beats in order.
- WB_COLLISION_CHECK_EN: capture addrs 0x005/0x006/0x005/0x007. Expect:
  - addr_collision=1 and all four beats still issued;
  - after a subsequent distinct-address capture, addr_collision=0.
